// File: rtl/fifo_row_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_row_loader_if
//  Description : Host-write, start/stall and downstream-fifo signal bundle
//                for fifo_row_loader. The master side is the host/MMIO block
//                plus the downstream stall source; the slave side is the
//                loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_row_loader_if #(
   parameter int DEPTH = 8,
   parameter int BITS  = 64
);
   // host staging writes and stream control
   logic                     wr_en;
   logic [$clog2(DEPTH)-1:0] wr_addr;
   logic [BITS-1:0]          wr_data;
   logic                     start;
   logic                     stall;

   // downstream fifo feed and status back to the register block
   logic                     fifo_en;
   logic [BITS-1:0]          fifo_d;
   logic                     busy;
   logic                     done;
   logic                     err;

   modport master (
      output wr_en, wr_addr, wr_data, start, stall,
      input  fifo_en, fifo_d, busy, done, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stall,
      output fifo_en, fifo_d, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/fifo_row_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_row_loader
//  Description : Stages up to DEPTH row words written by the host, then on a
//                start strobe streams them into the downstream delay-buffer
//                fifo followed by PAD zero words that flush the delay line.
//                Reports busy / done / sticky error to the register block.
//  Options     : LOADER_REVERSE_EN - when defined, rows are streamed from
//                staging[DEPTH-1] down to staging[0].
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_row_loader #(
   parameter int DEPTH = 8,
   parameter int BITS  = 64,
   parameter int PAD   = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   fifo_row_loader_if.slave  bus
);

   // staging address width and a one-bit-wider row counter so that the
   // value DEPTH is representable without wrapping back to zero
   localparam int C_AW = $clog2(DEPTH);
   localparam int C_IW = C_AW + 1;
   // pad counter only needs to reach PAD-1; keep at least one bit for PAD=0
   localparam int C_PW = (PAD > 0) ? $clog2(PAD + 1) : 1;

   localparam logic [C_IW-1:0] C_IDX_LAST = C_IW'(DEPTH - 1);
   localparam logic [C_PW-1:0] C_PAD_LAST = C_PW'((PAD > 0) ? (PAD - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // registered state
   state_t              r_state;
   logic [C_IW-1:0]     r_idx;
   logic [C_PW-1:0]     r_pad_cnt;
   logic                r_fifo_en;
   logic [BITS-1:0]     r_fifo_d;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic [BITS-1:0]     r_stage [DEPTH];

   // next-state values from the combinational process
   state_t              w_state_nxt;
   logic [C_IW-1:0]     w_idx_nxt;
   logic [C_PW-1:0]     w_pad_nxt;
   logic                w_fifo_en_nxt;
   logic [BITS-1:0]     w_fifo_d_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_err_nxt;
   logic                w_stage_we;
   logic [C_AW-1:0]     w_rd_idx;

   // Row selection for the stream. DEPTH is a power of two, so the low
   // C_AW bits of the counter address every row exactly once.
`ifdef LOADER_REVERSE_EN
   assign w_rd_idx = C_AW'(DEPTH - 1) - r_idx[C_AW-1:0];
`else
   assign w_rd_idx = r_idx[C_AW-1:0];
`endif

   // FSM next-state and output decode; every output is registered below
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_pad_nxt     = r_pad_cnt;
      w_fifo_en_nxt = 1'b0;
      w_fifo_d_nxt  = r_fifo_d;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_err_nxt     = r_err;
      w_stage_we    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // writes land at the same edge as a coincident start, so the
            // stream (which first reads one edge later) sees the new row
            w_stage_we = bus.wr_en;
            if (bus.start) begin
               w_state_nxt = ST_STREAM;
               w_idx_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_err_nxt   = 1'b0;
            end
         end

         ST_STREAM: begin
            if (bus.wr_en) begin
               w_err_nxt = 1'b1;
            end
            if (!bus.stall) begin
               w_fifo_en_nxt = 1'b1;
               w_fifo_d_nxt  = r_stage[w_rd_idx];
               w_idx_nxt     = r_idx + 1'b1;
               if (r_idx == C_IDX_LAST) begin
                  if (PAD == 0) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_state_nxt = ST_FLUSH;
                     w_pad_nxt   = '0;
                  end
               end
            end
         end

         ST_FLUSH: begin
            if (bus.wr_en) begin
               w_err_nxt = 1'b1;
            end
            if (!bus.stall) begin
               w_fifo_en_nxt = 1'b1;
               w_fifo_d_nxt  = '0;
               w_pad_nxt     = r_pad_cnt + 1'b1;
               if (r_pad_cnt == C_PAD_LAST) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            // busy is still asserted throughout this cycle, so a write here
            // is still an illegal access; stall has no effect on completion
            if (bus.wr_en) begin
               w_err_nxt = 1'b1;
            end
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // counters and registered outputs; reset drops fifo_en immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= '0;
         r_pad_cnt <= '0;
         r_fifo_en <= 1'b0;
         r_fifo_d  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_idx     <= w_idx_nxt;
         r_pad_cnt <= w_pad_nxt;
         r_fifo_en <= w_fifo_en_nxt;
         r_fifo_d  <= w_fifo_d_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // staging rows: cleared on reset, written only while idle, and otherwise
   // retained so that a later start replays the same rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else if (w_stage_we) begin
         r_stage[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.fifo_en = r_fifo_en;
   assign bus.fifo_d  = r_fifo_d;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_row_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_row_loader
//  Description : Self-checking bench for fifo_row_loader. A PAD=8 instance
//                covers the main scenarios; a PAD=0 instance covers the
//                no-flush build. Expected streams come from a row-array model
//                and a "one word per unstalled cycle" timing rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_row_loader;

   localparam int DEPTH = 8;
   localparam int BITS  = 64;
   localparam int PAD   = 8;
   localparam int AW    = $clog2(DEPTH);
`ifdef LOADER_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus, steered to one instance by sel (0: PAD=8, 1: PAD=0)
   logic            sel     = 1'b0;
   logic            wr_en   = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [BITS-1:0] wr_data = '0;
   logic            start   = 1'b0;
   logic            stall   = 1'b0;

   fifo_row_loader_if #(.DEPTH(DEPTH), .BITS(BITS)) bus  ();
   fifo_row_loader_if #(.DEPTH(DEPTH), .BITS(BITS)) bus0 ();

   assign bus.wr_en    = wr_en & ~sel;
   assign bus.wr_addr  = wr_addr;
   assign bus.wr_data  = wr_data;
   assign bus.start    = start & ~sel;
   assign bus.stall    = stall;
   assign bus0.wr_en   = wr_en & sel;
   assign bus0.wr_addr = wr_addr;
   assign bus0.wr_data = wr_data;
   assign bus0.start   = start & sel;
   assign bus0.stall   = stall;

   fifo_row_loader #(.DEPTH(DEPTH), .BITS(BITS), .PAD(PAD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   fifo_row_loader #(.DEPTH(DEPTH), .BITS(BITS), .PAD(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   logic            o_en, o_busy, o_done, o_err;
   logic [BITS-1:0] o_d;
   assign o_en   = sel ? bus0.fifo_en : bus.fifo_en;
   assign o_d    = sel ? bus0.fifo_d  : bus.fifo_d;
   assign o_busy = sel ? bus0.busy    : bus.busy;
   assign o_done = sel ? bus0.done    : bus.done;
   assign o_err  = sel ? bus0.err     : bus.err;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [BITS-1:0] m_stage  [DEPTH];
   logic [BITS-1:0] m0_stage [DEPTH];
   bit              stall_pat [64];
   logic [BITS-1:0] exp_w [$];
   int              exp_c [$];
   int              exp_done;

   // observations from the last stream
   logic [BITS-1:0] got_w [$];
   int              got_c [$];
   int              done_cyc, done_cnt, busy_cnt;
   logic            busy0, err0, err_at_done;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input bit s, input int a, input logic [BITS-1:0] d);
      sel     = s;
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      step();
      wr_en = 1'b0;
      if (s) m0_stage[a] = d;
      else   m_stage[a]  = d;
   endtask

   task automatic clear_stalls();
      for (int c = 0; c < 64; c++) stall_pat[c] = 1'b0;
   endtask

   // Expected stream: the rows in order (or reversed), then PAD zeros; each
   // word takes the next unstalled cycle after start, done one cycle later.
   task automatic build_expect(input bit s);
      int n, k, c;
      exp_w.delete();
      exp_c.delete();
      for (int i = 0; i < DEPTH; i++) begin
         int r;
         r = REV ? (DEPTH - 1 - i) : i;
         exp_w.push_back(s ? m0_stage[r] : m_stage[r]);
      end
      n = s ? 0 : PAD;
      for (int i = 0; i < n; i++) exp_w.push_back('0);
      k = 0;
      c = 1;
      while (k < exp_w.size()) begin
         if (!stall_pat[c]) begin
            exp_c.push_back(c);
            k++;
         end
         c++;
      end
      exp_done = exp_c[exp_c.size() - 1] + 1;
   endtask

   // Pulse start (cycle 0 = the accepting edge), then run bounded cycles
   // applying stall_pat, an optional illegal write and an optional re-start.
   task automatic run_stream(input int bad_wr_at, input int restart_at);
      got_w.delete();
      got_c.delete();
      done_cyc    = -1;
      done_cnt    = 0;
      busy_cnt    = 0;
      err_at_done = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      wr_en = 1'b0;
      busy0 = o_busy;
      err0  = o_err;
      for (int c = 1; c <= 60; c++) begin
         stall   = stall_pat[c];
         wr_en   = (c == bad_wr_at);
         wr_addr = AW'(2);
         wr_data = {$urandom(), $urandom()};
         start   = (c == restart_at);
         step();
         stall = 1'b0;
         wr_en = 1'b0;
         start = 1'b0;
         if (o_en) begin
            got_w.push_back(o_d);
            got_c.push_back(c);
         end
         if (o_busy) busy_cnt++;
         if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc    = c;
               err_at_done = o_err;
            end
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.fifo_en !== 1'b0) begin errors++; $display("FAIL reset_fifo_en got %b want 0", bus.fifo_en); end
      checks++; if (bus.fifo_d !== '0) begin errors++; $display("FAIL reset_fifo_d got %h want 0", bus.fifo_d); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
      for (int i = 0; i < DEPTH; i++) begin
         m_stage[i]  = '0;
         m0_stage[i] = '0;
      end
      #10 rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [BITS-1:0] unit;
      unit = 64'h0101_0101_0101_0101;
      clear_stalls();
      for (int i = 0; i < DEPTH; i++) write_row(1'b0, i, unit * BITS'(i + 1));
      build_expect(1'b0);
      run_stream(-1, -1);
      checks++; if (got_w.size() !== exp_w.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", got_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size(); i++) begin
         logic [BITS-1:0] gw; int gc;
         gw = (i < got_w.size()) ? got_w[i] : 'x;
         gc = (i < got_c.size()) ? got_c[i] : -1;
         checks++;
         if (gw !== exp_w[i] || gc !== exp_c[i]) begin
            errors++;
            $display("FAIL basic_word%0d got %h@T+%0d want %h@T+%0d", i, gw, gc, exp_w[i], exp_c[i]);
         end
      end
      checks++; if (done_cyc !== 17) begin errors++; $display("FAIL basic_done_cycle got T+%0d want T+17", done_cyc); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_at_T got %b want 1", busy0); end
      checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", busy_cnt); end
      checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err_at_done); end
   endtask

   task automatic test_stall();
      clear_stalls();
      for (int c = 3; c <= 5; c++) stall_pat[c] = 1'b1;
      build_expect(1'b0);
      run_stream(-1, -1);
      checks++; if (got_w.size() !== exp_w.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", got_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size(); i++) begin
         logic [BITS-1:0] gw; int gc;
         gw = (i < got_w.size()) ? got_w[i] : 'x;
         gc = (i < got_c.size()) ? got_c[i] : -1;
         checks++;
         if (gw !== exp_w[i] || gc !== exp_c[i]) begin
            errors++;
            $display("FAIL stall_word%0d got %h@T+%0d want %h@T+%0d", i, gw, gc, exp_w[i], exp_c[i]);
         end
      end
      checks++; if (done_cyc !== 20) begin errors++; $display("FAIL stall_done_cycle got T+%0d want T+20", done_cyc); end
      checks++; if (busy_cnt !== 19) begin errors++; $display("FAIL stall_busy_cycles got %0d want 19", busy_cnt); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         clear_stalls();
         for (int c = 1; c <= 30; c++) stall_pat[c] = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < DEPTH; i++) write_row(1'b0, i, {$urandom(), $urandom()});
         // overwrite a random row once more to exercise last-write-wins
         write_row(1'b0, $urandom_range(0, DEPTH - 1), {$urandom(), $urandom()});
         build_expect(1'b0);
         run_stream(-1, -1);
         checks++; if (got_w.size() !== exp_w.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, got_w.size(), exp_w.size()); end
         for (int i = 0; i < exp_w.size(); i++) begin
            logic [BITS-1:0] gw; int gc;
            gw = (i < got_w.size()) ? got_w[i] : 'x;
            gc = (i < got_c.size()) ? got_c[i] : -1;
            checks++;
            if (gw !== exp_w[i] || gc !== exp_c[i]) begin
               errors++;
               $display("FAIL rand%0d_word%0d got %h@T+%0d want %h@T+%0d", it, i, gw, gc, exp_w[i], exp_c[i]);
            end
         end
         checks++; if (done_cyc !== exp_done) begin errors++; $display("FAIL rand%0d_done got T+%0d want T+%0d", it, done_cyc, exp_done); end
      end
   endtask

   task automatic test_illegal();
      clear_stalls();
      build_expect(1'b0);
      run_stream(5, 7);
      checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL illegal_err_set got %b want 1", err_at_done); end
      checks++; if (done_cyc !== 17) begin errors++; $display("FAIL illegal_done_cycle got T+%0d want T+17", done_cyc); end
      checks++; if (got_w.size() !== exp_w.size()) begin errors++; $display("FAIL illegal_count got %0d want %0d", got_w.size(), exp_w.size()); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky got %b want 1", o_err); end
      // replay: staging[2] must be untouched and start must clear err
      run_stream(-1, -1);
      checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL illegal_err_cleared got %b want 0", err0); end
      for (int i = 0; i < exp_w.size(); i++) begin
         logic [BITS-1:0] gw;
         gw = (i < got_w.size()) ? got_w[i] : 'x;
         checks++;
         if (gw !== exp_w[i]) begin
            errors++;
            $display("FAIL replay_word%0d got %h want %h", i, gw, exp_w[i]);
         end
      end
   endtask

   task automatic test_write_with_start();
      logic [BITS-1:0] d;
      int a;
      clear_stalls();
      a = $urandom_range(0, DEPTH - 1);
      d = {$urandom(), $urandom()};
      sel     = 1'b0;
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      m_stage[a] = d;
      build_expect(1'b0);
      run_stream(-1, -1);
      for (int i = 0; i < DEPTH; i++) begin
         logic [BITS-1:0] gw;
         gw = (i < got_w.size()) ? got_w[i] : 'x;
         checks++;
         if (gw !== exp_w[i]) begin
            errors++;
            $display("FAIL wrstart_word%0d got %h want %h", i, gw, exp_w[i]);
         end
      end
   endtask

   task automatic test_pad_zero();
      clear_stalls();
      for (int i = 0; i < DEPTH; i++) write_row(1'b1, i, {$urandom(), $urandom()} | 64'h1);
      build_expect(1'b1);
      run_stream(-1, -1);
      checks++; if (got_w.size() !== DEPTH) begin errors++; $display("FAIL pad0_count got %0d want %0d", got_w.size(), DEPTH); end
      for (int i = 0; i < exp_w.size(); i++) begin
         logic [BITS-1:0] gw; int gc;
         gw = (i < got_w.size()) ? got_w[i] : 'x;
         gc = (i < got_c.size()) ? got_c[i] : -1;
         checks++;
         if (gw !== exp_w[i] || gc !== exp_c[i]) begin
            errors++;
            $display("FAIL pad0_word%0d got %h@T+%0d want %h@T+%0d", i, gw, gc, exp_w[i], exp_c[i]);
         end
      end
      checks++; if (done_cyc !== 9) begin errors++; $display("FAIL pad0_done_cycle got T+%0d want T+9", done_cyc); end
      sel = 1'b0;
   endtask

   task automatic test_reset_midstream();
      int dones;
      clear_stalls();
      sel   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 4; c++) step();
      checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL midrst_streaming got en=%b want 1", o_en); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL midrst_fifo_en got %b want 0", o_en); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", o_busy); end
      for (int i = 0; i < DEPTH; i++) begin
         m_stage[i]  = '0;
         m0_stage[i] = '0;
      end
      #3 rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (o_done) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", dones); end
      build_expect(1'b0);
      run_stream(-1, -1);
      for (int i = 0; i < DEPTH; i++) begin
         logic [BITS-1:0] gw;
         gw = (i < got_w.size()) ? got_w[i] : 'x;
         checks++;
         if (gw !== exp_w[i]) begin
            errors++;
            $display("FAIL midrst_cleared_word%0d got %h want %h", i, gw, exp_w[i]);
         end
      end
      checks++; if (done_cyc !== 17) begin errors++; $display("FAIL midrst_done_cycle got T+%0d want T+17", done_cyc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random();
      test_illegal();
      test_write_with_start();
      test_pad_zero();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
